// File: rtl/uart_tx.sv
// UART transmitter: 5-8 data bits, optional even/odd parity, 1 or 2 stop bits,
// bit timing driven by an external 16x/13x oversample enable.
module uart_tx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       OSM_SEL,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       STB,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [2:0] bit_idx_reg, bit_idx_next;
  logic       stop_idx_reg, stop_idx_next;
  logic [7:0] data_reg, data_next;
  logic [1:0] wls_reg, wls_next;
  logic       pen_reg, pen_next;
  logic       eps_reg, eps_next;
  logic       stb_reg, stb_next;
  logic       osm_reg, osm_next;
  logic       tx_reg, tx_next;
  logic       busy_reg, busy_next;
  logic       done_reg, done_next;

  logic       last_tick;
  logic [7:0] word_mask;
  logic       parity_bit;
  logic [2:0] bit_idx_inc;

  // A bit ends on the en pulse that finds the counter at N-1.
  assign last_tick   = en && (cnt_reg == (osm_reg ? 4'd12 : 4'd15));
  assign word_mask   = 8'hFF >> (2'd3 - wls_reg);
  assign parity_bit  = eps_reg ? (^(data_reg & word_mask)) : ~(^(data_reg & word_mask));
  assign bit_idx_inc = bit_idx_reg + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      bit_idx_reg  <= 3'd0;
      stop_idx_reg <= 1'b0;
      data_reg     <= 8'd0;
      wls_reg      <= 2'd0;
      pen_reg      <= 1'b0;
      eps_reg      <= 1'b0;
      stb_reg      <= 1'b0;
      osm_reg      <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      bit_idx_reg  <= bit_idx_next;
      stop_idx_reg <= stop_idx_next;
      data_reg     <= data_next;
      wls_reg      <= wls_next;
      pen_reg      <= pen_next;
      eps_reg      <= eps_next;
      stb_reg      <= stb_next;
      osm_reg      <= osm_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    bit_idx_next  = bit_idx_reg;
    stop_idx_next = stop_idx_reg;
    data_next     = data_reg;
    wls_next      = wls_reg;
    pen_next      = pen_reg;
    eps_next      = eps_reg;
    stb_next      = stb_reg;
    osm_next      = osm_reg;
    tx_next       = tx_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;

    if (state_reg != IDLE && en) begin
      cnt_next = last_tick ? 4'd0 : cnt_reg + 4'd1;
    end

    case (state_reg)
      IDLE: begin
        if (tx_start) begin
          data_next     = tx_data;
          wls_next      = WLS;
          pen_next      = PEN;
          eps_next      = EPS;
          stb_next      = STB;
          osm_next      = OSM_SEL;
          cnt_next      = 4'd0;
          bit_idx_next  = 3'd0;
          stop_idx_next = 1'b0;
          tx_next       = 1'b0;
          busy_next     = 1'b1;
          state_next    = START;
        end
      end
      START: begin
        if (last_tick) begin
          bit_idx_next = 3'd0;
          tx_next      = data_reg[0];
          state_next   = DATA;
        end
      end
      DATA: begin
        if (last_tick) begin
          // Final data bit index is 4 + WLS.
          if (bit_idx_reg == {1'b1, wls_reg}) begin
            stop_idx_next = 1'b0;
            if (pen_reg) begin
              tx_next    = parity_bit;
              state_next = PARITY;
            end else begin
              tx_next    = 1'b1;
              state_next = STOP;
            end
          end else begin
            bit_idx_next = bit_idx_inc;
            tx_next      = data_reg[bit_idx_inc];
          end
        end
      end
      PARITY: begin
        if (last_tick) begin
          stop_idx_next = 1'b0;
          tx_next       = 1'b1;
          state_next    = STOP;
        end
      end
      STOP: begin
        if (last_tick) begin
          if (stb_reg && !stop_idx_reg) begin
            stop_idx_next = 1'b1;
          end else begin
            tx_next    = 1'b1;
            busy_next  = 1'b0;
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: begin
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign tx      = tx_reg;
  assign tx_busy = busy_reg;
  assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: hand-computed frame waveforms checked per bit,
// with mid-frame config/start disturbances, back-to-back frames and reset abort.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       osm_sel = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic [1:0] wls = 2'd0;
  logic       pen = 1'b0;
  logic       eps = 1'b0;
  logic       stb = 1'b0;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  uart_tx dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .OSM_SEL  (osm_sel),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .WLS      (wls),
    .PEN      (pen),
    .EPS      (eps),
    .STB      (stb),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Called just after a negedge; returns just after the negedge sampling tx_done,
  // so an immediate second call starts the next frame in the clk after tx_done.
  task automatic run_frame(input string name, input logic [7:0] d, input logic [1:0] w,
                           input logic p, input logic e, input logic s, input logic o,
                           input int per, input logic [11:0] bits, input int nbits);
    int width, total, busy_cnt, early_done;
    int match[12];
    width = (o ? 13 : 16) * per;
    total = nbits * width;
    busy_cnt = 0;
    early_done = 0;
    for (int b = 0; b < 12; b++) match[b] = 0;
    tx_data = d; wls = w; pen = p; eps = e; stb = s; osm_sel = o;
    tx_start = 1'b1;
    en = 1'b1;
    for (int k = 0; k <= total; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k < total) begin
        if (tx == bits[k / width]) match[k / width]++;
        if (tx_busy) busy_cnt++;
        if (tx_done) early_done++;
      end else begin
        chk({name, " done"}, int'(tx_done), 1);
        chk({name, " busy_end"}, int'(tx_busy), 0);
        chk({name, " tx_end"}, int'(tx), 1);
      end
      // Halfway through: ignored second start plus scrambled data/config.
      tx_start = (k + 1 == total / 2);
      if (k + 1 == total / 2) begin
        tx_data = 8'hFF; wls = ~w; pen = ~p; eps = ~e; stb = ~s; osm_sel = ~o;
      end
      en = ((k + 1) % per == 0);
    end
    for (int b = 0; b < nbits; b++) chk($sformatf("%s bit%0d", name, b), match[b], width);
    chk({name, " busy"}, busy_cnt, total);
    chk({name, " early_done"}, early_done, 0);
    $display("frame %s data=%02h bits=%0d width=%0d clks=%0d", name, d, nbits, width, total);
  endtask

  task automatic idle(input int n);
    int ok;
    ok = 0;
    en = 1'b1;
    tx_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (tx === 1'b1 && tx_busy === 1'b0 && tx_done === 1'b0) ok++;
    end
    chk("idle", ok, n);
  endtask

  // 0xC1, 8N1: data bit 3 is 0. Freeze en there, then reset mid-bit.
  task automatic abort_frame();
    int frz_tx, frz_busy, done_seen;
    frz_tx = 0; frz_busy = 0; done_seen = 0;
    tx_data = 8'hC1; wls = 2'b11; pen = 1'b0; eps = 1'b0; stb = 1'b0; osm_sel = 1'b0;
    tx_start = 1'b1;
    en = 1'b1;
    for (int k = 0; k <= 68; k++) begin
      @(posedge clk);
      @(negedge clk);
      tx_start = 1'b0;
    end
    en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (tx == 1'b0) frz_tx++;
      if (tx_busy) frz_busy++;
    end
    chk("freeze tx", frz_tx, 40);
    chk("freeze busy", frz_busy, 40);
    rst_n = 1'b0;
    #1;
    chk("abort tx", int'(tx), 1);
    chk("abort busy", int'(tx_busy), 0);
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_done) done_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_done) done_seen++;
    end
    chk("abort no_done", done_seen, 0);
    $display("frame abort data=c1 reset during data bit3");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset tx", int'(tx), 1);
    chk("reset busy", int'(tx_busy), 0);
    chk("reset done", int'(tx_done), 0);
    rst_n = 1'b1;
    idle(4);
    // 0x55 8N1, 16x: 0,1,0,1,0,1,0,1,0,1
    run_frame("f55", 8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1, 12'h2AA, 10);
    idle(3);
    // 0xE3 5E2, 13x: 0,1,1,0,0,0,par0,1,1 -> 117 en pulses
    run_frame("fe3", 8'hE3, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1, 12'h186, 9);
    idle(3);
    // 0x80 7O1: bit7 dropped, parity 1
    run_frame("f80", 8'h80, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1, 12'h300, 10);
    idle(3);
    // 0xA6 8E1 with en 1 clk in 4: 64-clk bits
    run_frame("fa6", 8'hA6, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 4, 12'h54C, 11);
    idle(3);
    // Back-to-back: 0x3C 6N2 13x, then 0x0B 5O1 16x with zero gap
    run_frame("f3c", 8'h3C, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1, 12'h1F8, 9);
    run_frame("f0b", 8'h0B, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1, 12'h096, 8);
    idle(3);
    abort_frame();
    // 0x5A 8O2 after reset abort
    run_frame("f5a", 8'h5A, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1, 12'hEB4, 12);
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameters: none; all frame options SHALL be runtime inputs.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 en  input  1  one-clk oversample enable pulse from the baud generator; only clocks carrying en=1 advance bit timing.
REQ-005 OSM_SEL  input  1  oversample mode: 0 = 16 en pulses per bit, 1 = 13 en pulses per bit.
REQ-006 tx_start  input  1  one-clk request to send one frame.
REQ-007 tx_data  input  8  frame payload, LSB transmitted first.
REQ-008 WLS  input  2  word length select: 00=5, 01=6, 10=7, 11=8 data bits.
REQ-009 PEN  input  1  parity enable.
REQ-010 EPS  input  1  even parity select: 1 = even, 0 = odd.
REQ-011 STB  input  1  stop bits: 0 = one, 1 = two.
REQ-012 tx  output  1  serial line, idle high.
REQ-013 tx_busy  output  1  high from the frame accept cycle until tx_done.
REQ-014 tx_done  output  1  one-clk pulse when the last stop bit ends.

Function
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; all outputs registered.
REQ-016 In IDLE with tx_start=1, the block SHALL latch tx_data, WLS, PEN, EPS, STB and OSM_SEL, clear the bit-timing counter, and enter START; tx SHALL go low and tx_busy high on the following clock edge.
REQ-017 Config inputs and tx_data SHALL be ignored after the accept cycle; changes mid-frame SHALL NOT affect the frame in flight.
REQ-018 tx_start outside IDLE SHALL be ignored (no queueing, no error).
REQ-019 Bit timing: 4-bit counter SHALL increment only on en=1; when en=1 and counter = N-1 (N = 16 or 13 per latched OSM_SEL), it SHALL wrap to 0 and the FSM SHALL advance one bit; each bit therefore spans exactly N en pulses.
REQ-020 START: tx=0 for one bit time, then DATA.
REQ-021 DATA: tx = latched data bit i, i = 0 upward; after bit (4+WLS) the FSM SHALL go to PARITY if PEN=1, else STOP.
REQ-022 PARITY: tx = XOR of the transmitted data bits when EPS=1, its inverse when EPS=0; bits above the selected word length SHALL NOT contribute.
REQ-023 STOP: tx=1 for one bit time (STB=0) or two bit times (STB=1).
REQ-024 At the end of the final stop bit the FSM SHALL return to IDLE, pulse tx_done for one clk and drop tx_busy in the same clk; tx SHALL remain 1.
REQ-025 A tx_start in the clk after tx_done SHALL be accepted, giving back-to-back frames with no extra idle bit.
REQ-026 en held low SHALL freeze counter and state indefinitely with tx stable.
REQ-027 Frame length = 1 + (5..8) + PEN + (1..2) bits; total en pulses = N x length.

Reset
REQ-028 rst_n=0 SHALL immediately, regardless of state: state=IDLE, counter=0, bit index=0, latched registers=0, tx=1, tx_busy=0, tx_done=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame without a tx_done pulse; after release the block SHALL accept a new tx_start normally.

Verification
REQ-030 OSM_SEL=0, WLS=11, PEN=0, STB=0, tx_data=0x55, en every clk -> tx: 0,1,0,1,0,1,0,1,0,1, each level 16 clks; tx_done at clk 160 after start.
REQ-031 OSM_SEL=1, WLS=00, PEN=1, EPS=1, STB=1, tx_data=0xE3 -> data 1,1,0,0,0, parity 0, two stop bits; each bit 13 en pulses; 117 en pulses total.
REQ-032 PEN=1, EPS=0, WLS=10, tx_data=0x80 -> bit7 ignored, parity bit = 1; changing tx_data to 0xFF mid-frame leaves the waveform unchanged.
REQ-033 en asserted 1 clk in 4, tx_start pulsed again mid-frame -> bit width 64 clks, second start ignored, single tx_done.
REQ-034 rst_n pulsed low during DATA bit 3 -> tx=1 and tx_busy=0 immediately, no tx_done; next tx_start sends a complete, correct frame.
REQ-035 tx_start in the clk after tx_done -> new start bit begins with zero idle gap; both frames bit-exact.
